// File: rtl/pll_lock_det_pkg.sv
// Shared types and default constants for the PLL lock detector.
package pll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_t;

    localparam int WIN       = 1024;
    localparam int TOL       = 2;
    localparam int LOCK_CNT  = 4;
    localparam int BRAKE_TOL = 16;
    localparam int CW        = 12;

endpackage

// File: rtl/pll_lock_det_if.sv
// Measurement/status bundle between a PLL controller and the lock detector.
interface pll_lock_det_if #(
    parameter int CW = 12
) ();

    logic          enable;
    logic          fb_tgl;
    logic          locked;
    logic          lock_lost;
    logic [CW-1:0] fb_count;
    logic          count_valid;
    logic          brake_req;

    modport master (
        output enable, fb_tgl,
        input  locked, lock_lost, fb_count, count_valid, brake_req
    );

    modport slave (
        input  enable, fb_tgl,
        output locked, lock_lost, fb_count, count_valid, brake_req
    );

endinterface

// File: rtl/pll_lock_det_sync_edge.sv
// Two-flop synchronizer for the feedback toggle plus a history flop for
// any-polarity edge detection; free-running independent of enable.
module pll_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_edge  = r_s2 ^ r_s3;

endmodule

// File: rtl/pll_lock_det.sv
// PLL lock detector: counts feedback toggles per refclk window and tracks lock.
// Define LOCK_DET_BRAKE_EN to enable the overshoot brake request on brake_req.
module pll_lock_det
    import pll_pkg::*;
#(
    parameter int WIN       = pll_pkg::WIN,
    parameter int TOL       = pll_pkg::TOL,
    parameter int LOCK_CNT  = pll_pkg::LOCK_CNT,
    parameter int BRAKE_TOL = pll_pkg::BRAKE_TOL,
    parameter int CW        = pll_pkg::CW
) (
    input  logic          refclk,
    input  logic          resetn,
    input  logic          enable,
    input  logic          fb_tgl,
    output logic          locked,
    output logic          lock_lost,
    output logic [CW-1:0] fb_count,
    output logic          count_valid,
    output logic          brake_req
);

    localparam int WW = $clog2(WIN);
    localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    // Lower bound clamps at zero so a wide tolerance cannot underflow.
    localparam logic [31:0] L_GOOD_LO = (WIN / 4 > TOL) ? 32'(WIN / 4 - TOL) : 32'd0;
    localparam logic [31:0] L_GOOD_HI = 32'(WIN / 4 + TOL);

    if (WIN < 16 || (WIN % 4) != 0 || TOL < 0 || LOCK_CNT < 1 || BRAKE_TOL < 0 || CW < 1)
    begin : g_bad_param
        $error("pll_lock_det: illegal parameter set");
    end

    lock_state_t   r_state;
    lock_state_t   w_state_nxt;
    logic [WW-1:0] r_wcnt;
    logic [CW-1:0] r_ecnt;
    logic [GW-1:0] r_gcnt;
    logic [GW-1:0] w_gcnt_nxt;
    logic [CW-1:0] r_fb_count;
    logic          r_cv;
    logic          r_lost;

    logic          w_edge;
    logic          w_win_end;
    logic [CW-1:0] w_total;
    logic [31:0]   w_total32;
    logic          w_good;
    logic          w_lose;

    pll_sync_edge u_sync (
        .i_clk   (refclk),
        .i_rst_n (resetn),
        .i_async (fb_tgl),
        .o_level (),
        .o_edge  (w_edge)
    );

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_win_end   = (r_state != ST_IDLE) && enable && (r_wcnt == WW'(WIN - 1));
        // Edge on the window-end cycle belongs to the closing window; saturate.
        w_total     = (r_ecnt == '1) ? r_ecnt : r_ecnt + CW'(w_edge);
        w_total32   = 32'(w_total);
        w_good      = (w_total32 >= L_GOOD_LO) && (w_total32 <= L_GOOD_HI);
        w_state_nxt = r_state;
        w_gcnt_nxt  = r_gcnt;
        w_lose      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gcnt_nxt = '0;
                if (enable) w_state_nxt = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_gcnt_nxt  = '0;
                end else if (w_win_end) begin
                    if (!w_good) begin
                        w_gcnt_nxt = '0;
                    end else if (r_gcnt == GW'(LOCK_CNT - 1)) begin
                        w_state_nxt = ST_LOCKED;
                        w_gcnt_nxt  = '0;
                    end else begin
                        w_gcnt_nxt = r_gcnt + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                w_gcnt_nxt = '0;
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_win_end && !w_good) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_lose      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            r_wcnt     <= '0;
            r_ecnt     <= '0;
            r_gcnt     <= '0;
            r_fb_count <= '0;
            r_cv       <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_gcnt <= w_gcnt_nxt;
            r_cv   <= w_win_end;
            r_lost <= w_lose;
            if (w_win_end) r_fb_count <= w_total;
            if (r_state == ST_IDLE || !enable || w_win_end) begin
                r_wcnt <= '0;
                r_ecnt <= '0;
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
                r_ecnt <= w_total;
            end
        end
    end

`ifdef LOCK_DET_BRAKE_EN
    localparam logic [31:0] L_BRAKE_HI = 32'(WIN / 4 + BRAKE_TOL);

    logic r_brake;

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) r_brake <= 1'b0;
        else         r_brake <= w_win_end && (w_total32 > L_BRAKE_HI);
    end

    assign brake_req = r_brake;
`else
    assign brake_req = 1'b0;
`endif

    assign locked      = (r_state == ST_LOCKED);
    assign lock_lost   = r_lost;
    assign count_valid = r_cv;
    assign fb_count    = r_fb_count;

endmodule

// File: tb/tb_pll_lock_det.sv
// Directed bench for pll_lock_det: acquisition, lock loss, saturation,
// enable drop and asynchronous reset, with a phase-accumulator fb_tgl source.
module tb_pll_lock_det;

    logic refclk = 1'b0;
    logic resetn = 1'b0;
    logic en     = 1'b0;
    logic fb_lvl = 1'b0;

    logic       locked8;
    logic       lock_lost8;
    logic [7:0] fb_count8;
    logic       count_valid8;
    logic       brake_req8;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef LOCK_DET_BRAKE_EN
    localparam logic EXP_BRAKE = 1'b1;
`else
    localparam logic EXP_BRAKE = 1'b0;
`endif

    always #5 refclk = ~refclk;

    pll_lock_det_if #(.CW(12)) u_if ();

    assign u_if.enable = en;
    assign u_if.fb_tgl = fb_lvl;

    pll_lock_det #(
        .WIN(1024), .TOL(2), .LOCK_CNT(4), .BRAKE_TOL(16), .CW(12)
    ) u_dut (
        .refclk      (refclk),
        .resetn      (resetn),
        .enable      (u_if.enable),
        .fb_tgl      (u_if.fb_tgl),
        .locked      (u_if.locked),
        .lock_lost   (u_if.lock_lost),
        .fb_count    (u_if.fb_count),
        .count_valid (u_if.count_valid),
        .brake_req   (u_if.brake_req)
    );

    pll_lock_det #(
        .WIN(1024), .TOL(2), .LOCK_CNT(4), .BRAKE_TOL(16), .CW(8)
    ) u_dut8 (
        .refclk      (refclk),
        .resetn      (resetn),
        .enable      (u_if.enable),
        .fb_tgl      (u_if.fb_tgl),
        .locked      (locked8),
        .lock_lost   (lock_lost8),
        .fb_count    (fb_count8),
        .count_valid (count_valid8),
        .brake_req   (brake_req8)
    );

    // fb_tgl source: toggles whenever acc (+2 per cycle) reaches fb_p2 half-cycles;
    // fb_p2 = 0 stops it. Extra toggles go into cycles without a regular toggle.
    int unsigned fb_p2       = 8;
    int unsigned fb_acc      = 0;
    int unsigned fb_xtra_req = 0;
    int unsigned fb_xtra_cnt = 0;

    always @(negedge refclk) begin
        logic hit;
        hit = 1'b0;
        if (fb_p2 != 0) begin
            fb_acc = fb_acc + 2;
            if (fb_acc >= fb_p2) begin
                fb_acc = fb_acc - fb_p2;
                hit    = 1'b1;
            end
        end
        if (hit) begin
            fb_lvl = ~fb_lvl;
        end else if (fb_xtra_cnt < fb_xtra_req) begin
            fb_lvl      = ~fb_lvl;
            fb_xtra_cnt = fb_xtra_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic wait_cv(output int unsigned n);
        n = 0;
        do begin
            @(posedge refclk);
            #1;
            n++;
        end while (u_if.count_valid !== 1'b1 && n < 1100);
        chk("cv_seen", 32'(u_if.count_valid), 32'd1);
    endtask

    initial begin
        int unsigned n;
        logic        seen;
        logic [31:0] cnt;

        // Reset state
        tick(3);
        chk("rst_flags", {28'd0, u_if.locked, u_if.lock_lost, u_if.count_valid, u_if.brake_req}, 32'd0);
        chk("rst_fb_count", 32'(u_if.fb_count), 32'd0);
        chk("rst_fb_count8", 32'(fb_count8), 32'd0);
        resetn = 1'b1;
        tick(5);

        // Steady 4-cycle toggle: four good windows then lock
        en = 1'b1;
        wait_cv(n);
        chk("w1_latency", n, 32'd1025);
        chk("w1_count", 32'(u_if.fb_count), 32'd256);
        chk("w1_locked", 32'(u_if.locked), 32'd0);
        wait_cv(n);
        chk("w2_period", n, 32'd1024);
        chk("w2_count", 32'(u_if.fb_count), 32'd256);
        wait_cv(n);
        chk("w3_locked", 32'(u_if.locked), 32'd0);
        wait_cv(n);
        chk("w4_count", 32'(u_if.fb_count), 32'd256);
        chk("w4_locked", 32'(u_if.locked), 32'd1);
        chk("w4_lost", 32'(u_if.lock_lost), 32'd0);
        chk("w4_brake", 32'(u_if.brake_req), 32'd0);

        // Overshoot to ~292 counts while locked
        fb_p2 = 7;
        wait_cv(n);
        cnt = 32'(u_if.fb_count);
        chk("w5_count_range", 32'(cnt >= 32'd290 && cnt <= 32'd294), 32'd1);
        chk("w5_lost", 32'(u_if.lock_lost), 32'd1);
        chk("w5_locked", 32'(u_if.locked), 32'd0);
        chk("w5_brake", 32'(u_if.brake_req), 32'(EXP_BRAKE));
        chk("w5_sat8", 32'(fb_count8), 32'd255);
        tick(1);
        chk("w5_pulse_end", {29'd0, u_if.lock_lost, u_if.brake_req, u_if.count_valid}, 32'd0);

        // Acquisition restart: 256, 259, 256 x4 -> lock after sixth window
        fb_p2 = 8;
        en    = 1'b0;
        tick(10);
        chk("idle_locked", 32'(u_if.locked), 32'd0);
        en = 1'b1;
        wait_cv(n);
        chk("a1_latency", n, 32'd1025);
        chk("a1_count", 32'(u_if.fb_count), 32'd256);
        tick(100);
        fb_xtra_req = fb_xtra_req + 3;
        wait_cv(n);
        chk("a2_count", 32'(u_if.fb_count), 32'd259);
        chk("a2_locked", 32'(u_if.locked), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_cv(n);
            chk("a3_count", 32'(u_if.fb_count), 32'd256);
            chk("a3_locked", 32'(u_if.locked), 32'(i == 3));
        end

        // Enable dropped mid-window while locked
        tick(300);
        en = 1'b0;
        tick(1);
        chk("off_flags", {29'd0, u_if.locked, u_if.lock_lost, u_if.count_valid}, 32'd0);
        fb_p2 = 0;
        seen  = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            tick(1);
            seen = seen | u_if.count_valid | u_if.lock_lost;
        end
        chk("off_quiet", 32'(seen), 32'd0);

        // Stuck feedback: zero counts, never locks
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_cv(n);
            chk("stuck_count", 32'(u_if.fb_count), 32'd0);
            chk("stuck_locked", 32'(u_if.locked), 32'd0);
        end

        // Toggle every refclk: 1024 at CW=12, saturates at 255 with CW=8
        en    = 1'b0;
        fb_p2 = 2;
        tick(5);
        en = 1'b1;
        wait_cv(n);
        chk("fast_count", 32'(u_if.fb_count), 32'd1024);
        chk("fast_count8", 32'(fb_count8), 32'd255);
        chk("fast_brake", 32'(u_if.brake_req), 32'(EXP_BRAKE));
        chk("fast_locked", 32'(u_if.locked), 32'd0);

        // Lock again, then asynchronous reset mid-window
        en    = 1'b0;
        fb_p2 = 8;
        tick(5);
        en = 1'b1;
        for (int i = 0; i < 4; i++) wait_cv(n);
        chk("r_locked", 32'(u_if.locked), 32'd1);
        tick(500);
        resetn = 1'b0;
        #1;
        chk("r_async_flags", {28'd0, u_if.locked, u_if.lock_lost, u_if.count_valid, u_if.brake_req}, 32'd0);
        chk("r_async_fb", 32'(u_if.fb_count), 32'd0);
        tick(3);
        resetn = 1'b1;
        wait_cv(n);
        chk("r_restart_latency", n, 32'd1025);
        chk("r_restart_count", 32'(u_if.fb_count), 32'd256);
        chk("r_restart_locked", 32'(u_if.locked), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pll_lock_det.md
PLL_LOCK_DET -- requirements
Module: pll_lock_det

Interface
REQ-001 SHALL have parameter WIN, default 1024, meaning refclk cycles per measurement window (multiple of 4, >= 16).
REQ-002 SHALL have parameter TOL, default 2, meaning allowed |count - WIN/4| for a good window.
REQ-003 SHALL have parameter LOCK_CNT, default 4, meaning consecutive good windows required to declare lock.
REQ-004 SHALL have parameter BRAKE_TOL, default 16, meaning overshoot above WIN/4 that triggers a brake request.
REQ-005 SHALL have parameter CW, default 12, meaning width of the edge counter and fb_count.
REQ-006 SHALL have port refclk  input  1  reference clock; the block's only clock.
REQ-007 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port enable  input  1  level; measurement runs while high.
REQ-009 SHALL have port fb_tgl  input  1  asynchronous level from the PLL feedback path, toggling once per 4 feedback-divider cycles.
REQ-010 SHALL have port locked  output  1  high while in LOCKED.
REQ-011 SHALL have port lock_lost  output  1  one-cycle pulse on LOCKED->ACQUIRE.
REQ-012 SHALL have port fb_count  output  CW  edge count of the last completed window.
REQ-013 SHALL have port count_valid  output  1  one-cycle pulse when fb_count updates.
REQ-014 SHALL have port brake_req  output  1  one-cycle supply-droop brake request to the PLL brake input.

Function
REQ-015 SHALL pass fb_tgl through a 2-flop synchronizer plus one history flop, and SHALL count one event per synchronized edge (both polarities, s2 XOR s3); input-to-count latency is 3 refclk cycles.
REQ-016 SHALL run window counter wcnt 0..WIN-1 while enable is high; a window ends on the cycle wcnt == WIN-1.
REQ-017 SHALL include an edge event occurring on the window-end cycle in that window, then restart the edge counter at 0.
REQ-018 SHALL saturate the edge counter at 2^CW-1 (no wrap).
REQ-019 SHALL load fb_count and pulse count_valid on the cycle after window end.
REQ-020 SHALL classify a window as good when WIN/4-TOL <= count <= WIN/4+TOL (unsigned compare, no underflow when TOL > WIN/4).
REQ-021 SHALL implement FSM states IDLE, ACQUIRE, LOCKED.
REQ-022 IDLE: wcnt, edge counter, and good-window counter held at 0; enable high -> ACQUIRE next cycle, first window starts there.
REQ-023 ACQUIRE: good window increments the good-window counter; bad window clears it; reaching LOCK_CNT -> LOCKED, locked high on the cycle after window end (same cycle as count_valid).
REQ-024 LOCKED: bad window -> ACQUIRE, locked low, and lock_lost pulsed, both on the cycle after window end; good-window counter cleared.
REQ-025 enable low in any state -> IDLE next cycle, locked low, partial window discarded, no lock_lost or count_valid pulse.
REQ-026 Synchronizer flops SHALL keep running while enable is low, so a re-enable sees no spurious edge.

Reset
REQ-027 On resetn low, all flops SHALL clear asynchronously: state IDLE; locked, lock_lost, count_valid, and brake_req 0; fb_count 0; synchronizer 0.
REQ-028 Reset mid-window SHALL discard the window and lock status; after release, operation restarts from IDLE.

Configuration
REQ-029 With LOCK_DET_BRAKE_EN defined, brake_req SHALL pulse together with count_valid whenever count > WIN/4+BRAKE_TOL, in any non-IDLE state.
REQ-030 Without LOCK_DET_BRAKE_EN, brake_req SHALL be tied to 0 and the overshoot comparator omitted; the port remains.

Structure
REQ-031 The shared package pll_pkg SHALL hold the state enum type lock_state_t and default constants (WIN, TOL, LOCK_CNT, BRAKE_TOL).
REQ-032 The synchronizer and edge detector SHALL be a sub-module, pll_sync_edge (input async level; output synchronized level and edge pulse).

Verification
REQ-033 fb_tgl toggling every 4 refclk cycles, enable at t0 -> fb_count=256 each window; locked rises 1 cycle after the 4th window end (4096 refclk cycles + 1).
REQ-034 Locked, then fb_tgl period changed to 3.5 refclk cycles (count ~292) -> lock_lost pulse and locked low 1 cycle after that window end; with LOCK_DET_BRAKE_EN, brake_req pulses in the same cycle.
REQ-035 Window counts 256, 259, 256, 256, 256, 256 -> the second window resets acquisition; locked rises after the 6th window.
REQ-036 fb_tgl stuck at 0 -> fb_count=0 every window, locked never rises; fb_tgl toggling every refclk -> count saturates only if CW=8 (255).
REQ-037 enable dropped mid-window while locked -> locked low next cycle, no lock_lost or count_valid; resetn pulsed mid-window -> all outputs 0 immediately.
